// File: rtl/fsb_line_prefetch_term_pkg.sv
// rtl/fsb_line_prefetch_term_pkg.sv - shared widths and FSM state codes for the FSB line prefetch terminator
package fsb_line_prefetch_term_pkg;

   // Width of the fill timeout counter and of the hit counter
   localparam int TO_W  = 8;
   localparam int HIT_W = 16;

   typedef logic [2:0] stateT;

   localparam stateT ST_IDLE    = 3'd0;
   localparam stateT ST_LOOKUP  = 3'd1;
   localparam stateT ST_FILL    = 3'd2;
   localparam stateT ST_TERM    = 3'd3;
   localparam stateT ST_WAIT_AS = 3'd4;

   // Tag width for a given line size
   function automatic int tagWidth(input int lineBits);
      return 32 - lineBits;
   endfunction

endpackage

// File: rtl/fsb_line_prefetch_term_if.sv
// rtl/fsb_line_prefetch_term_if.sv - CPU bus and SDRAM fill handshake bundle
interface fsb_line_prefetch_term_if
   import fsb_line_prefetch_term_pkg::*;
#(
   parameter int LINE_BITS = 4
);
   logic [31:0]          FSB_A;
   logic                 FSB_RnW;
   logic                 CPU_nAS;
   logic                 CPU_nCIOUT;
   logic                 FLUSH;
   logic                 FILL_REQ;
   logic [31-LINE_BITS:0] FILL_A;
   logic                 FILL_ACK;
   logic                 FILL_ERR;
   logic                 CPU_nSTERM;
   logic                 CPU_nBERR;
   logic [HIT_W-1:0]     HIT_CNT;

   // CPU and SDRAM side: drives the bus pins and fill acknowledge
   modport master (
      output FSB_A, FSB_RnW, CPU_nAS, CPU_nCIOUT, FLUSH, FILL_ACK, FILL_ERR,
      input  FILL_REQ, FILL_A, CPU_nSTERM, CPU_nBERR, HIT_CNT
   );

   // Line buffer side
   modport slave (
      input  FSB_A, FSB_RnW, CPU_nAS, CPU_nCIOUT, FLUSH, FILL_ACK, FILL_ERR,
      output FILL_REQ, FILL_A, CPU_nSTERM, CPU_nBERR, HIT_CNT
   );
endinterface

// File: rtl/fsb_line_prefetch_term_tag_cam.sv
// rtl/fsb_line_prefetch_term_tag_cam.sv - valid/tag storage with parallel compare
module fsb_tag_cam #(
   parameter int ENTRIES = 4,
   parameter int TAG_W   = 28,
   localparam int IW     = $clog2(ENTRIES)
) (
   input  logic             FSBCLK,
   input  logic             nRES,
   input  logic [TAG_W-1:0] cmpTag,
   output logic             anyHit,
   input  logic             installEn,
   input  logic [IW-1:0]    installIdx,
   input  logic [TAG_W-1:0] installTag,
   input  logic             invalEn,
   input  logic             flush
);
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tags [ENTRIES];
   logic [ENTRIES-1:0] hitVec;

   // Compare the looked-up tag against every valid entry at once
   always_comb begin
      hitVec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hitVec[i] = valid[i] && (tags[i] == cmpTag);
      end
   end

   assign anyHit = |hitVec;

   // Flush beats install so a line filled during a flush is never left valid
   always_ff @(posedge FSBCLK or negedge nRES) begin
      if (!nRES) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) tags[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (installEn && (installIdx == IW'(i))) tags[i] <= installTag;
            if (flush) valid[i] <= 1'b0;
            else if (installEn && (installIdx == IW'(i))) valid[i] <= 1'b1;
            else if (invalEn && hitVec[i]) valid[i] <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/fsb_line_prefetch_term.sv
// rtl/fsb_line_prefetch_term.sv - N-entry line-tag buffer terminating cacheable FSB read hits
module fsb_line_prefetch_term
   import fsb_line_prefetch_term_pkg::*;
#(
   parameter int ENTRIES   = 4,
   parameter int LINE_BITS = 4,
   parameter int TIMEOUT   = 255
) (
   input logic FSBCLK,
   input logic nRES,
   fsb_line_prefetch_term_if.slave bus
);
   localparam int TAG_W = tagWidth(LINE_BITS);
   localparam int VW    = $clog2(ENTRIES);

   stateT            state;
   logic             asPrev;
   logic [TAG_W-1:0] latTag;
   logic             latRnW;
   logic             latCiOut;
   logic             fillReq;
   logic [TAG_W-1:0] fillA;
   logic             nSterm;
   logic             nBerr;
   logic [HIT_W-1:0] hitCnt;
   logic [VW-1:0]    victim;
   logic [TO_W-1:0]  timer;
   logic             fromFill;
   logic             aborted;
   logic             abortNow;
   logic             anyHit;
   logic             installEn;
   logic             invalEn;
   logic             unusedLowA;

   assign unusedLowA = ^bus.FSB_A[LINE_BITS-1:0];

   // The CPU may drop AS at any point of the fill; once seen, the cycle is abandoned
   assign abortNow  = aborted || bus.CPU_nAS;
   assign installEn = (state == ST_FILL) && bus.FILL_ACK && !bus.FILL_ERR && latCiOut;
   assign invalEn   = (state == ST_LOOKUP) && !latRnW;

   fsb_tag_cam #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) tagCam (
      .FSBCLK     (FSBCLK),
      .nRES       (nRES),
      .cmpTag     (latTag),
      .anyHit     (anyHit),
      .installEn  (installEn),
      .installIdx (victim),
      .installTag (latTag),
      .invalEn    (invalEn),
      .flush      (bus.FLUSH)
   );

   // Victim pointer advances round-robin on every install
   always_ff @(posedge FSBCLK or negedge nRES) begin
      if (!nRES) victim <= '0;
      else if (installEn) victim <= victim + VW'(1);
   end

   // Bus cycle FSM: latch, lookup, fill with timeout, terminate, wait for AS release
   always_ff @(posedge FSBCLK or negedge nRES) begin
      if (!nRES) begin
         state    <= ST_IDLE;
         asPrev   <= 1'b1;
         latTag   <= '0;
         latRnW   <= 1'b1;
         latCiOut <= 1'b1;
         fillReq  <= 1'b0;
         fillA    <= '0;
         nSterm   <= 1'b1;
         nBerr    <= 1'b1;
         hitCnt   <= '0;
         timer    <= '0;
         fromFill <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         asPrev <= bus.CPU_nAS;
         nSterm <= 1'b1;
         nBerr  <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!bus.CPU_nAS && asPrev) begin
                  latTag   <= bus.FSB_A[31:LINE_BITS];
                  latRnW   <= bus.FSB_RnW;
                  latCiOut <= bus.CPU_nCIOUT;
                  state    <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (!latRnW) begin
                  state <= ST_WAIT_AS;
               end else if (latCiOut && anyHit) begin
                  fromFill <= 1'b0;
                  state    <= ST_TERM;
               end else begin
                  fillReq <= 1'b1;
                  fillA   <= latTag;
                  timer   <= '0;
                  aborted <= 1'b0;
                  state   <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (bus.CPU_nAS) aborted <= 1'b1;
               if (bus.FILL_ACK) begin
                  fillReq <= 1'b0;
                  if (bus.FILL_ERR) begin
                     if (!abortNow) nBerr <= 1'b0;
                     state <= ST_WAIT_AS;
                  end else begin
                     fromFill <= 1'b1;
                     state    <= abortNow ? ST_WAIT_AS : ST_TERM;
                  end
               end else if (timer == TO_W'(TIMEOUT - 1)) begin
                  fillReq <= 1'b0;
                  if (!abortNow) nBerr <= 1'b0;
                  state <= ST_WAIT_AS;
               end else begin
                  timer <= timer + TO_W'(1);
               end
            end
            ST_TERM: begin
               nSterm <= 1'b0;
               if (!fromFill) hitCnt <= hitCnt + HIT_W'(1);
               state <= ST_WAIT_AS;
            end
            ST_WAIT_AS: begin
               if (bus.CPU_nAS) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.FILL_REQ   = fillReq;
   assign bus.FILL_A     = fillA;
   assign bus.CPU_nSTERM = nSterm;
   assign bus.CPU_nBERR  = nBerr;
   assign bus.HIT_CNT    = hitCnt;
endmodule

// File: tb/tb_fsb_line_prefetch_term.sv
// tb/tb_fsb_line_prefetch_term.sv - self-checking bench for fsb_line_prefetch_term
module tb_fsb_line_prefetch_term;
   localparam int ENTRIES = 4;
   localparam int TIMEOUT = 255;

   logic FSBCLK = 1'b0;
   logic nRES;
   int   checks   = 0;
   int   failures = 0;

   fsb_line_prefetch_term_if #(.LINE_BITS(4)) bus ();

   fsb_line_prefetch_term #(.ENTRIES(ENTRIES), .LINE_BITS(4), .TIMEOUT(TIMEOUT)) dut (
      .FSBCLK (FSBCLK),
      .nRES   (nRES),
      .bus    (bus)
   );

   always #5 FSBCLK = ~FSBCLK;

   // Reference: line buffer with round-robin replacement
   logic [27:0] mTag [ENTRIES];
   bit          mValid [ENTRIES];
   int          mVict;
   int          mHits;

   function automatic bit modelHas(input logic [27:0] t);
      for (int i = 0; i < ENTRIES; i++) if (mValid[i] && mTag[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelClear();
      for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
   endtask

   task automatic modelInstall(input logic [27:0] t, input bit flushing);
      mTag[mVict]   = t;
      mValid[mVict] = !flushing;
      mVict = (mVict + 1) % ENTRIES;
   endtask

   task automatic modelInval(input logic [27:0] t);
      for (int i = 0; i < ENTRIES; i++) if (mTag[i] == t) mValid[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge FSBCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic endCycle();
      bus.CPU_nAS = 1'b1;
      step();
      step();
   endtask

   task automatic startCycle(input logic [31:0] a, input bit rnw, input bit ciOut);
      bus.FSB_A      = a;
      bus.FSB_RnW    = rnw;
      bus.CPU_nCIOUT = ciOut;
      bus.CPU_nAS    = 1'b0;
      step();
      step();
   endtask

   // Full read cycle; hit/miss expectation comes from the model. errAck selects ACK+ERR.
   task automatic busRead(input logic [27:0] t, input bit ciOut, input bit errAck);
      bit expHit;
      int w;
      expHit = ciOut && modelHas(t);
      startCycle({t, 4'($urandom_range(0, 15))}, 1'b1, ciOut);
      check("lookup_sterm", 32'(bus.CPU_nSTERM), 32'd1);
      check("lookup_fillreq", 32'(bus.FILL_REQ), expHit ? 32'd0 : 32'd1);
      if (expHit) begin
         mHits++;
         step();
         check("hit_sterm", 32'(bus.CPU_nSTERM), 32'd0);
         check("hit_cnt", 32'(bus.HIT_CNT), 32'(mHits & 16'hFFFF));
         step();
         check("hit_sterm_end", 32'(bus.CPU_nSTERM), 32'd1);
      end else begin
         check("fill_a", 32'(bus.FILL_A), 32'(t));
         w = $urandom_range(0, 3);
         for (int i = 0; i < w; i++) begin
            step();
            check("fill_hold", 32'(bus.FILL_REQ), 32'd1);
            check("fill_a_hold", 32'(bus.FILL_A), 32'(t));
         end
         bus.FILL_ACK = 1'b1;
         bus.FILL_ERR = errAck;
         step();
         bus.FILL_ACK = 1'b0;
         bus.FILL_ERR = 1'b0;
         check("ack_fillreq", 32'(bus.FILL_REQ), 32'd0);
         if (errAck) begin
            check("err_berr", 32'(bus.CPU_nBERR), 32'd0);
            check("err_sterm", 32'(bus.CPU_nSTERM), 32'd1);
            step();
            check("err_berr_end", 32'(bus.CPU_nBERR), 32'd1);
         end else begin
            check("fill_sterm_pre", 32'(bus.CPU_nSTERM), 32'd1);
            step();
            check("fill_sterm", 32'(bus.CPU_nSTERM), 32'd0);
            check("fill_hitcnt", 32'(bus.HIT_CNT), 32'(mHits & 16'hFFFF));
            step();
            check("fill_sterm_end", 32'(bus.CPU_nSTERM), 32'd1);
            if (ciOut) modelInstall(t, 1'b0);
         end
      end
      endCycle();
   endtask

   task automatic busWrite(input logic [27:0] t);
      startCycle({t, 4'h8}, 1'b0, 1'b1);
      check("wr_fillreq", 32'(bus.FILL_REQ), 32'd0);
      check("wr_sterm", 32'(bus.CPU_nSTERM), 32'd1);
      step();
      check("wr_sterm2", 32'(bus.CPU_nSTERM), 32'd1);
      check("wr_berr", 32'(bus.CPU_nBERR), 32'd1);
      modelInval(t);
      endCycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [27:0] pool [6];
      logic [27:0] t;
      int          r;
      pool[0] = 28'h0000123; pool[1] = 28'h00A0001; pool[2] = 28'h0BEEF00;
      pool[3] = 28'h0000124; pool[4] = 28'hFFFFFFF; pool[5] = 28'h0000000;

      nRES = 1'b0;
      bus.FSB_A = '0; bus.FSB_RnW = 1'b1; bus.CPU_nAS = 1'b1; bus.CPU_nCIOUT = 1'b1;
      bus.FLUSH = 1'b0; bus.FILL_ACK = 1'b0; bus.FILL_ERR = 1'b0;
      modelClear(); mVict = 0; mHits = 0;
      step(); step();
      check("rst_fillreq", 32'(bus.FILL_REQ), 32'd0);
      check("rst_filla", 32'(bus.FILL_A), 32'd0);
      check("rst_sterm", 32'(bus.CPU_nSTERM), 32'd1);
      check("rst_berr", 32'(bus.CPU_nBERR), 32'd1);
      check("rst_hitcnt", 32'(bus.HIT_CNT), 32'd0);
      nRES = 1'b1;
      step(); step();

      // Miss then hit on line 0x0000123
      busRead(28'h0000123, 1'b1, 1'b0);
      busRead(28'h0000123, 1'b1, 1'b0);
      check("t1_hitcnt", 32'(bus.HIT_CNT), 32'd1);

      // Five distinct lines: the first is evicted, the three newest still hit
      for (int i = 0; i < 5; i++) busRead(28'h0400000 + 28'(i), 1'b1, 1'b0);
      busRead(28'h0400002, 1'b1, 1'b0);
      busRead(28'h0400003, 1'b1, 1'b0);
      busRead(28'h0400004, 1'b1, 1'b0);
      busRead(28'h0400000, 1'b1, 1'b0);

      // Write snoop invalidates a hit line
      busRead(28'h0000123, 1'b1, 1'b0);
      busRead(28'h0000123, 1'b1, 1'b0);
      busWrite(28'h0000123);
      busRead(28'h0000123, 1'b1, 1'b0);

      // Cache-inhibited reads never install
      busRead(28'h0777777, 1'b0, 1'b0);
      busRead(28'h0777777, 1'b0, 1'b0);
      busRead(28'h0777777, 1'b1, 1'b0);

      // Fill timeout, then a late ACK that must be ignored
      startCycle(32'h0555_5550, 1'b1, 1'b1);
      check("to_start", 32'(bus.FILL_REQ), 32'd1);
      repeat (TIMEOUT - 1) step();
      check("to_hold", 32'(bus.FILL_REQ), 32'd1);
      step();
      check("to_drop", 32'(bus.FILL_REQ), 32'd0);
      check("to_berr", 32'(bus.CPU_nBERR), 32'd0);
      step();
      check("to_berr_end", 32'(bus.CPU_nBERR), 32'd1);
      repeat (300 - TIMEOUT - 2) step();
      bus.FILL_ACK = 1'b1;
      step();
      bus.FILL_ACK = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_sterm", 32'(bus.CPU_nSTERM), 32'd1);
         check("late_berr", 32'(bus.CPU_nBERR), 32'd1);
         check("late_fillreq", 32'(bus.FILL_REQ), 32'd0);
         step();
      end
      endCycle();
      busRead(28'h0555555, 1'b1, 1'b1);
      busRead(28'h0555555, 1'b1, 1'b0);

      // Abort: AS released mid-fill, line still installed, no termination
      startCycle(32'h0666_6660, 1'b1, 1'b1);
      check("ab_fillreq", 32'(bus.FILL_REQ), 32'd1);
      bus.CPU_nAS = 1'b1;
      step();
      bus.FILL_ACK = 1'b1;
      step();
      bus.FILL_ACK = 1'b0;
      check("ab_ackdrop", 32'(bus.FILL_REQ), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("ab_sterm", 32'(bus.CPU_nSTERM), 32'd1);
         check("ab_berr", 32'(bus.CPU_nBERR), 32'd1);
         step();
      end
      modelInstall(28'h0666666, 1'b0);
      busRead(28'h0666666, 1'b1, 1'b0);

      // Randomised mix against the reference
      for (int n = 0; n < 40; n++) begin
         t = pool[$urandom_range(0, 5)];
         r = $urandom_range(0, 9);
         if (r <= 6) busRead(t, 1'b1, 1'b0);
         else if (r == 7) busRead(t, 1'b0, 1'b0);
         else busWrite(t);
      end

      // Reset during a fill
      busRead(28'h0123456, 1'b1, 1'b0);
      startCycle(32'h0ABC_DEF0, 1'b1, 1'b1);
      check("rf_fillreq", 32'(bus.FILL_REQ), 32'd1);
      #2 nRES = 1'b0;
      #1;
      check("rf_async_drop", 32'(bus.FILL_REQ), 32'd0);
      check("rf_hitcnt", 32'(bus.HIT_CNT), 32'd0);
      bus.CPU_nAS = 1'b1;
      step();
      nRES = 1'b1;
      modelClear(); mVict = 0; mHits = 0;
      step(); step();
      busRead(28'h0123456, 1'b1, 1'b0);
      busRead(28'h0123456, 1'b1, 1'b0);

      // FLUSH coincident with an install leaves the line invalid
      startCycle(32'h0DDD_DDD0, 1'b1, 1'b1);
      check("fl_fillreq", 32'(bus.FILL_REQ), 32'd1);
      bus.FILL_ACK = 1'b1;
      bus.FLUSH    = 1'b1;
      step();
      bus.FILL_ACK = 1'b0;
      bus.FLUSH    = 1'b0;
      step();
      check("fl_sterm", 32'(bus.CPU_nSTERM), 32'd0);
      step();
      modelClear();
      modelInstall(28'h0DDDDDD, 1'b1);
      endCycle();
      busRead(28'h0DDDDDD, 1'b1, 1'b0);
      busRead(28'h0123456, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
